hex_keypad_encoder: RTL and testbench

- Input-side counterpart of the 7-segment hex display path. Scans a 4x4 matrix keypad and encodes the debounced key into a 4-bit hex value (0-F).
- Delivers that value to the core or MMIO layer through a valid/ready handshake.
- Sits between the board keypad pins and the memory-mapped input register, alongside the display decoders.

---
 rtl/hex_keypad_encoder.sv | 212 +++++++++++++++++++++
 tb/tb_hex_keypad_encoder.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_keypad_encoder.sv
// -----------------------------------------------------------------------------
// hex_keypad_encoder
//
// Scans a 4x4 active-low matrix keypad, debounces the key it finds, and
// encodes it to a 4-bit hex code (0-F). The code is offered to the consumer
// through a valid/ready handshake.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   row_n[3:0]   keypad rows, active-low, asynchronous to clk
//   col_n[3:0]   column drive, active-low, exactly one bit low
//   key_value    hex code of the last accepted key
//   key_valid    key_value holds an unconsumed key
//   key_ready    consumer takes key_value when key_valid && key_ready
//   key_pressed  high while a debounced key is held
//   key_overrun  one-cycle pulse: a key replaced an unconsumed key
// -----------------------------------------------------------------------------
module hex_keypad_encoder #(
    parameter int SCAN_DIV       = 50000,  // cycles per column slot, >= 4
    parameter int DEBOUNCE_SCANS = 4       // matching samples needed, 1..15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key_value,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       key_pressed,
    output logic       key_overrun
);

    localparam int              PW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_MAX = PW'(SCAN_DIV - 1);
    localparam logic [3:0]      DB_TARGET = 4'(DEBOUNCE_SCANS);
    localparam bit              DB_ONE    = (DEBOUNCE_SCANS == 1);

    localparam logic [1:0] ST_SCAN       = 2'd0;
    localparam logic [1:0] ST_PRESS_DB   = 2'd1;
    localparam logic [1:0] ST_HELD       = 2'd2;
    localparam logic [1:0] ST_RELEASE_DB = 2'd3;

    logic [3:0]    sync1_q, sync1_d;
    logic [3:0]    sync2_q, sync2_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    state_q, state_d;
    logic [1:0]    col_q, col_d;
    logic [1:0]    row_q, row_d;
    logic [3:0]    db_cnt_q, db_cnt_d;
    logic [3:0]    key_value_q, key_value_d;
    logic          key_valid_q, key_valid_d;
    logic          key_pressed_q, key_pressed_d;
    logic          key_overrun_q, key_overrun_d;

    logic [3:0] rs;
    logic       tick;
    logic       accept;
    logic [3:0] cnt_inc;

    assign rs      = sync2_q;
    assign tick    = (presc_q == PRESC_MAX);
    assign cnt_inc = db_cnt_q + 4'd1;

    // Lowest-index low row wins when several rows read low together.
    function automatic logic [1:0] lowest_low(input logic [3:0] r);
        if (!r[0])      lowest_low = 2'd0;
        else if (!r[1]) lowest_low = 2'd1;
        else if (!r[2]) lowest_low = 2'd2;
        else            lowest_low = 2'd3;
    endfunction

    // Keypad legend: row0 1 2 3 A / row1 4 5 6 B / row2 7 8 9 C / row3 E 0 F D
    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'h0: key_map = 4'h1;  4'h1: key_map = 4'h2;
            4'h2: key_map = 4'h3;  4'h3: key_map = 4'hA;
            4'h4: key_map = 4'h4;  4'h5: key_map = 4'h5;
            4'h6: key_map = 4'h6;  4'h7: key_map = 4'hB;
            4'h8: key_map = 4'h7;  4'h9: key_map = 4'h8;
            4'hA: key_map = 4'h9;  4'hB: key_map = 4'hC;
            4'hC: key_map = 4'hE;  4'hD: key_map = 4'h0;
            4'hE: key_map = 4'hF;  default: key_map = 4'hD;
        endcase
    endfunction

    always_comb begin
        // NOTE: every signal written here gets a default first; a path that
        // left one unassigned would infer a latch.
        sync1_d       = row_n;
        sync2_d       = sync1_q;
        presc_d       = tick ? '0 : presc_q + PW'(1);
        state_d       = state_q;
        col_d         = col_q;
        row_d         = row_q;
        db_cnt_d      = db_cnt_q;
        key_pressed_d = key_pressed_q;
        accept        = 1'b0;

        // The column only moves on a tick, so it stays frozen for the whole
        // time a key is being debounced or held.
        if (tick) begin
            case (state_q)
                ST_SCAN: begin
                    if (rs != 4'hF) begin
                        row_d    = lowest_low(rs);
                        db_cnt_d = 4'd1;
                        if (DB_ONE) begin
                            accept  = 1'b1;
                            state_d = ST_HELD;
                        end else begin
                            state_d = ST_PRESS_DB;
                        end
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end
                ST_PRESS_DB: begin
                    if (!rs[row_q]) begin
                        if (cnt_inc == DB_TARGET) begin
                            accept  = 1'b1;
                            state_d = ST_HELD;
                        end else begin
                            db_cnt_d = cnt_inc;
                        end
                    end else begin
                        state_d = ST_SCAN;
                        col_d   = col_q + 2'd1;
                    end
                end
                ST_HELD: begin
                    // Only the latched row is watched; a second key is ignored.
                    if (rs[row_q]) begin
                        db_cnt_d = 4'd1;
                        if (DB_ONE) begin
                            key_pressed_d = 1'b0;
                            state_d       = ST_SCAN;
                            col_d         = col_q + 2'd1;
                        end else begin
                            state_d = ST_RELEASE_DB;
                        end
                    end
                end
                default: begin  // ST_RELEASE_DB
                    if (rs[row_q]) begin
                        if (cnt_inc == DB_TARGET) begin
                            key_pressed_d = 1'b0;
                            state_d       = ST_SCAN;
                            col_d         = col_q + 2'd1;
                        end else begin
                            db_cnt_d = cnt_inc;
                        end
                    end else begin
                        state_d = ST_HELD;
                    end
                end
            endcase
        end

        // Handshake: consumption clears valid; a new key takes precedence and
        // only counts as an overrun if the old key is not leaving this cycle.
        key_value_d   = key_value_q;
        key_valid_d   = key_valid_q;
        key_overrun_d = 1'b0;
        if (key_valid_q && key_ready) begin
            key_valid_d = 1'b0;
        end
        if (accept) begin
            key_value_d   = key_map(row_d, col_q);
            key_valid_d   = 1'b1;
            key_pressed_d = 1'b1;
            key_overrun_d = key_valid_q && !key_ready;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q       <= 4'b1111;
            sync2_q       <= 4'b1111;
            presc_q       <= '0;
            state_q       <= ST_SCAN;
            col_q         <= 2'd0;
            row_q         <= 2'd0;
            db_cnt_q      <= 4'd0;
            key_value_q   <= 4'd0;
            key_valid_q   <= 1'b0;
            key_pressed_q <= 1'b0;
            key_overrun_q <= 1'b0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            presc_q       <= presc_d;
            state_q       <= state_d;
            col_q         <= col_d;
            row_q         <= row_d;
            db_cnt_q      <= db_cnt_d;
            key_value_q   <= key_value_d;
            key_valid_q   <= key_valid_d;
            key_pressed_q <= key_pressed_d;
            key_overrun_q <= key_overrun_d;
        end
    end

    assign col_n       = ~(4'b0001 << col_q);
    assign key_value   = key_value_q;
    assign key_valid   = key_valid_q;
    assign key_pressed = key_pressed_q;
    assign key_overrun = key_overrun_q;

endmodule

// File: tb/tb_hex_keypad_encoder.sv
// -----------------------------------------------------------------------------
// tb_hex_keypad_encoder
//
// Directed bench for hex_keypad_encoder with SCAN_DIV = 4, DEBOUNCE_SCANS = 3.
// A small keypad model pulls a row low when a pressed key's column is driven.
// Outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_hex_keypad_encoder;

    localparam int SCAN_DIV       = 4;
    localparam int DEBOUNCE_SCANS = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [3:0] key_value;
    logic       key_valid;
    logic       key_ready;
    logic       key_pressed;
    logic       key_overrun;

    // One bit per key, index = row*4 + col.
    logic [15:0] keys;

    int n_cmp = 0;
    int n_err = 0;
    int ovr_cnt = 0;
    int rise_cnt = 0;
    logic pressed_prev = 1'b0;

    hex_keypad_encoder #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .row_n       (row_n),
        .col_n       (col_n),
        .key_value   (key_value),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .key_pressed (key_pressed),
        .key_overrun (key_overrun)
    );

    always #5 clk = ~clk;

    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (key_overrun === 1'b1) ovr_cnt++;
        if (key_pressed === 1'b1 && pressed_prev !== 1'b1) rise_cnt++;
        pressed_prev = key_pressed;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_col_change(input string tag, output int cyc);
        logic [3:0] prev;
        prev = col_n;
        cyc  = 0;
        while (col_n === prev && cyc < 64) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_changed"}, 32'(col_n !== prev), 32'd1);
    endtask

    task automatic wait_col_enter(input logic [3:0] target, input string tag, output int cyc);
        int n;
        n = 0;
        while (col_n === target && n < 64) begin
            @(negedge clk);
            n++;
        end
        cyc = 0;
        while (col_n !== target && cyc < 64) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_enter"}, 32'(col_n), 32'(target));
    endtask

    task automatic wait_valid(input logic exp, input string tag, output int cyc);
        cyc = 0;
        while (key_valid !== exp && cyc < 80) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_valid"}, 32'(key_valid), 32'(exp));
    endtask

    task automatic wait_pressed(input logic exp, input string tag);
        int cyc;
        cyc = 0;
        while (key_pressed !== exp && cyc < 80) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_pressed"}, 32'(key_pressed), 32'(exp));
    endtask

    task automatic consume();
        key_ready = 1'b1;
        @(negedge clk);
        key_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] rot_exp [4];
        int cyc;
        int obase;
        int rbase;

        rot_exp = '{4'b1011, 4'b0111, 4'b1110, 4'b1101};
        reset     = 1'b1;
        keys      = '0;
        key_ready = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_col_n",   32'(col_n),       32'hE);
        check("rst_valid",   32'(key_valid),   32'd0);
        check("rst_pressed", 32'(key_pressed), 32'd0);
        check("rst_value",   32'(key_value),   32'd0);
        check("rst_overrun", 32'(key_overrun), 32'd0);
        reset = 1'b0;

        // Idle rotation, one column every SCAN_DIV cycles
        wait_col_change("rot0", cyc);
        check("rot0_cycles", 32'(cyc), 32'd4);
        check("rot0_col", 32'(col_n), 32'hD);
        for (int i = 0; i < 4; i++) begin
            wait_col_change("rot", cyc);
            check("rot_cycles", 32'(cyc), 32'd4);
            check("rot_col", 32'(col_n), 32'(rot_exp[i]));
        end

        // Key 6 (row1/col2): latency, freeze, release
        keys[6] = 1'b1;
        wait_col_enter(4'b1011, "k6", cyc);
        wait_valid(1'b1, "k6", cyc);
        check("k6_latency", 32'(cyc), 32'd12);
        check("k6_value", 32'(key_value), 32'h6);
        check("k6_pressed_hi", 32'(key_pressed), 32'd1);
        repeat (28) @(negedge clk);
        check("k6_col_frozen", 32'(col_n), 32'hB);
        check("k6_still_pressed", 32'(key_pressed), 32'd1);
        keys = '0;
        wait_pressed(1'b0, "k6_rel");
        check("k6_resume_col3", 32'(col_n), 32'h7);
        check("k6_valid_kept", 32'(key_valid), 32'd1);
        consume();
        check("k6_consumed", 32'(key_valid), 32'd0);

        // Bounce on key 1 (row0/col0): one low sample only
        wait_col_enter(4'b1110, "bnc", cyc);
        keys[0] = 1'b1;
        repeat (4) @(negedge clk);
        keys[0] = 1'b0;
        wait_col_change("bnc", cyc);
        check("bnc_hold_cycles", 32'(cyc), 32'd4);
        check("bnc_next_col", 32'(col_n), 32'hD);
        check("bnc_no_valid", 32'(key_valid), 32'd0);
        check("bnc_no_pressed", 32'(key_pressed), 32'd0);

        // Key D (row3/col3)
        keys[15] = 1'b1;
        wait_valid(1'b1, "kd", cyc);
        check("kd_value", 32'(key_value), 32'hD);
        keys = '0;
        wait_pressed(1'b0, "kd_rel");
        consume();
        check("kd_consumed", 32'(key_valid), 32'd0);

        // Handshake: key 5 held valid until ready
        keys[5] = 1'b1;
        wait_valid(1'b1, "k5", cyc);
        check("k5_value", 32'(key_value), 32'h5);
        keys = '0;
        repeat (50) @(negedge clk);
        check("k5_valid_held", 32'(key_valid), 32'd1);
        check("k5_value_held", 32'(key_value), 32'h5);
        check("k5_released", 32'(key_pressed), 32'd0);
        consume();
        check("k5_consumed", 32'(key_valid), 32'd0);

        // Overrun: 1 then F with nothing consumed
        obase = ovr_cnt;
        keys[0] = 1'b1;
        wait_valid(1'b1, "ovr_k1", cyc);
        check("ovr_k1_value", 32'(key_value), 32'h1);
        keys = '0;
        wait_pressed(1'b0, "ovr_k1_rel");
        keys[14] = 1'b1;
        wait_pressed(1'b1, "ovr_kf");
        check("ovr_pulse", 32'(key_overrun), 32'd1);
        check("ovr_value", 32'(key_value), 32'hF);
        @(negedge clk);
        check("ovr_pulse_end", 32'(key_overrun), 32'd0);
        check("ovr_count", 32'(ovr_cnt - obase), 32'd1);
        check("ovr_valid", 32'(key_valid), 32'd1);
        keys = '0;
        wait_pressed(1'b0, "ovr_kf_rel");
        consume();
        check("ovr_consumed", 32'(key_valid), 32'd0);

        // Accept and consume on the same edge: no overrun
        obase = ovr_cnt;
        keys[0] = 1'b1;
        wait_valid(1'b1, "same_k1", cyc);
        keys = '0;
        wait_pressed(1'b0, "same_k1_rel");
        keys[14] = 1'b1;
        wait_col_enter(4'b1011, "same_kf", cyc);
        repeat (11) @(negedge clk);
        check("same_pre_value", 32'(key_value), 32'h1);
        key_ready = 1'b1;
        @(negedge clk);
        key_ready = 1'b0;
        check("same_value", 32'(key_value), 32'hF);
        check("same_valid", 32'(key_valid), 32'd1);
        check("same_no_pulse", 32'(key_overrun), 32'd0);
        @(negedge clk);
        check("same_ovr_count", 32'(ovr_cnt - obase), 32'd0);
        keys = '0;
        wait_pressed(1'b0, "same_kf_rel");
        consume();
        check("same_consumed", 32'(key_valid), 32'd0);

        // Two keys: 2 held, then 8 added in the same column
        rbase = rise_cnt;
        obase = ovr_cnt;
        keys[1] = 1'b1;
        wait_pressed(1'b1, "two_k2");
        check("two_value", 32'(key_value), 32'h2);
        keys[9] = 1'b1;
        repeat (30) @(negedge clk);
        check("two_value_kept", 32'(key_value), 32'h2);
        check("two_col", 32'(col_n), 32'hD);
        keys = '0;
        wait_pressed(1'b0, "two_rel");
        repeat (20) @(negedge clk);
        check("two_single_event", 32'(rise_cnt - rbase), 32'd1);
        check("two_no_overrun", 32'(ovr_cnt - obase), 32'd0);
        check("two_valid", 32'(key_valid), 32'd1);
        check("two_final_value", 32'(key_value), 32'h2);

        // Reset during PRESS_DB with a pending key
        wait_col_enter(4'b1110, "mid", cyc);
        keys[6] = 1'b1;
        wait_col_enter(4'b1011, "mid", cyc);
        repeat (6) @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_rst_col_n",   32'(col_n),       32'hE);
        check("mid_rst_valid",   32'(key_valid),   32'd0);
        check("mid_rst_value",   32'(key_value),   32'd0);
        check("mid_rst_pressed", 32'(key_pressed), 32'd0);
        check("mid_rst_overrun", 32'(key_overrun), 32'd0);
        keys = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        check("post_rst_valid", 32'(key_valid), 32'd0);
        check("post_rst_pressed", 32'(key_pressed), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
